axis_packetizer: RTL and testbench
==================================

// Module: axis_packetizer
// PURPOSE
//   Upstream framing stage for the AXI-Stream FIFO. Accepts an unframed beat stream,
//   cuts it into packets of a programmable length and drives TLAST on the last beat.
//   Output is fully registered through a 2-entry skid buffer, so throughput is 1 beat/clk
//   with no combinational path from M_AXIS_TREADY to S_AXIS_TREADY.
// PARAMETERS
//   WIDTH    8                      data width, bits
//   MAX_LEN  16                     maximum packet length, beats
//   LENWIDTH $clog2(MAX_LEN+1)      localparam; width of length/beat counters
// PORTS
//   clk            in   1         single clock; all logic on posedge
//   rst            in   1         synchronous, active-high reset
//   cfg_len        in   LENWIDTH  packet length in beats; sampled at packet start
//   S_AXIS_TDATA   in   WIDTH     upstream data
//   S_AXIS_TVALID  in   1         upstream valid
//   S_AXIS_TREADY  out  1         ready to accept a beat
//   M_AXIS_TDATA   out  WIDTH     framed data to the FIFO
//   M_AXIS_TVALID  out  1         framed valid
//   M_AXIS_TLAST   out  1         last beat of packet
//   M_AXIS_TREADY  in   1         downstream ready
//   pkt_done       out  1         1-cycle pulse when a TLAST beat is accepted upstream
//   pkt_count      out  16        packets framed since reset; wraps 0xFFFF -> 0
// BEHAVIOUR
//   Reset (rst=1 at posedge): M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0,
//     S_AXIS_TREADY=0 during reset, 1 on the first cycle after, pkt_done=0, pkt_count=0,
//     beat_cnt=0, state=IDLE, skid entries empty. Reset mid-packet drops all held beats.
//   Handshake: beat transfers when VALID&&READY at posedge. VALID never drops and DATA/LAST
//     never change while VALID=1 and READY=0.
//   S_AXIS_TREADY = skid buffer has at least one free entry (registered; depends only on
//     state, not on M_AXIS_TREADY in the same cycle).
//   Latency: beat accepted at edge N appears on M_AXIS at edge N+1 when the skid is empty.
//   FSM:
//     IDLE:   first accepted beat latches len_q = clamp(cfg_len). beat_cnt := 1.
//             If len_q==1, tag TLAST, pulse pkt_done and stay in IDLE.
//             Otherwise go to IN_PKT.
//     IN_PKT: each accepted beat increments beat_cnt.
//             When beat_cnt==len_q-1 on accept, tag TLAST, pulse pkt_done,
//             set beat_cnt := 0 and go to IDLE.
//   Length rules: cfg_len==0 -> treated as 1. cfg_len>MAX_LEN -> clamped to MAX_LEN.
//     Changing cfg_len mid-packet has no effect until the next IDLE accept.
//   TLAST travels with its beat through the skid buffer as bit WIDTH of the stored word.
//   pkt_count increments in the same cycle as pkt_done.
//     A simultaneous new first beat is legal (back-to-back packets, no bubble).
//   Skid buffer behaviour by case:
//     - Simultaneous push/pop with 1 entry held: count unchanged, order preserved.
//     - Full (2 entries): S_AXIS_TREADY=0 until a pop occurs.
//     - Empty: M_AXIS_TVALID=0.
// STRUCTURE
//   Package axis_pkg:
//     - typedef enum logic {IDLE, IN_PKT} pkt_state_t
//     - typedef struct packed {logic last; logic [WIDTH-1:0] data;} axis_beat_t, parameterised via
//       module-level WIDTH
//     - localparam PKT_CNT_W = 16
//   Sub-module axis_skid_buf #(WIDTH+1): 2-entry registered slice with the valid/ready pair on
//     each side; reusable by the FIFO's downstream stages.
//   Top level holds the FSM, beat_cnt, len_q, pkt_done and pkt_count.
// TESTING
//   1 cfg_len=4, 8 beats 0x00..0x07, M_AXIS_TREADY=1 -> TLAST on 0x03 and 0x07; pkt_done pulses 2x;
//     pkt_count=2; each beat out 1 cycle after accept.
//   2 cfg_len=3, M_AXIS_TREADY toggled 1010... -> no beat lost or duplicated; S_AXIS_TREADY never
//     asserted with 2 entries held; DATA/LAST stable while stalled.
//   3 cfg_len=0 then cfg_len=20 (MAX_LEN=16) -> every beat TLAST=1; then TLAST on every 16th beat.
//   4 cfg_len changed 4->2 after beat 1 of a 4-beat packet -> current packet still ends at beat 4;
//     next packet ends after 2 beats.
//   5 rst=1 for 1 cycle with 2 beats in skid, mid-packet -> next cycle M_AXIS_TVALID=0, pkt_count=0;
//     the next accepted beat starts a new packet using current cfg_len.
//   6 Pre-load pkt_count=0xFFFF via 65535 len-1 packets (or force) -> next packet wraps to 0x0000.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared types and constants for the AXI-Stream framing stages.
package axis_pkg;

    typedef enum logic {IDLE, IN_PKT} pkt_state_t;

    localparam int PKT_CNT_W = 16;

    // A zero length still yields a one-beat packet; overlong lengths saturate.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        if (len == 0)
            return 1;
        else if (len > max_len)
            return max_len;
        else
            return len;
    endfunction

endpackage

// File: rtl/axis_if.sv
// AXI-Stream bundle; the slave side carries no TLAST because the packetizer generates it.
interface axis_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;
    logic             tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_skid_buf.sv
// Two-entry registered slice: both ready and valid come straight from flops,
// so no combinational path crosses from out_ready to in_ready.
module axis_skid_buf #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    logic [WIDTH-1:0] head_reg, head_next;
    logic [WIDTH-1:0] tail_reg, tail_next;
    logic [1:0]       count_reg, count_next;
    logic             ready_reg;
    logic             push, pop;

    assign push      = in_valid & ready_reg;
    assign pop       = (count_reg != 2'd0) & out_ready;
    assign in_ready  = ready_reg;
    assign out_valid = (count_reg != 2'd0);
    assign out_data  = head_reg;

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        unique case ({push, pop})
            2'b10: begin
                if (count_reg == 2'd0)
                    head_next = in_data;
                else
                    tail_next = in_data;
                count_next = count_reg + 2'd1;
            end
            2'b01: begin
                head_next  = tail_reg;
                count_next = count_reg - 2'd1;
            end
            2'b11: begin
                // Head leaves while a new word arrives; order is kept by shifting tail forward.
                if (count_reg == 2'd1) begin
                    head_next = in_data;
                end else begin
                    head_next = tail_reg;
                    tail_next = in_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= 2'd0;
            ready_reg <= 1'b0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
            ready_reg <= (count_next != 2'd2);
        end
    end

endmodule

// File: rtl/axis_packetizer.sv
// Cuts an unframed beat stream into packets of cfg_len beats and tags TLAST,
// with the output side fully registered through a skid buffer.
module axis_packetizer
    import axis_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int MAX_LEN  = 16,
    localparam int LENWIDTH = $clog2(MAX_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LENWIDTH-1:0]  cfg_len,
    axis_if.slave                s_axis,
    axis_if.master               m_axis,
    output logic                 pkt_done,
    output logic [PKT_CNT_W-1:0] pkt_count
);
    typedef struct packed {
        logic             last;
        logic [WIDTH-1:0] data;
    } axis_beat_t;

    pkt_state_t           state_reg, state_next;
    logic [LENWIDTH-1:0]  beat_cnt_reg, beat_cnt_next;
    logic [LENWIDTH-1:0]  len_q_reg, len_q_next;
    logic [LENWIDTH-1:0]  len_cfg;
    logic                 pkt_done_reg;
    logic [PKT_CNT_W-1:0] pkt_count_reg;
    logic                 s_ready;
    logic                 accept;
    logic                 tag_last;
    axis_beat_t           in_beat, out_beat;

    assign len_cfg = LENWIDTH'(clamp_len(int'(cfg_len), MAX_LEN));
    assign accept  = s_axis.tvalid & s_ready;

    always_comb begin
        state_next    = state_reg;
        beat_cnt_next = beat_cnt_reg;
        len_q_next    = len_q_reg;
        tag_last      = 1'b0;
        if (accept) begin
            unique case (state_reg)
                IDLE: begin
                    len_q_next    = len_cfg;
                    beat_cnt_next = LENWIDTH'(1);
                    if (len_cfg == LENWIDTH'(1))
                        tag_last = 1'b1;
                    else
                        state_next = IN_PKT;
                end
                IN_PKT: begin
                    if (beat_cnt_reg == len_q_reg - LENWIDTH'(1)) begin
                        tag_last      = 1'b1;
                        beat_cnt_next = '0;
                        state_next    = IDLE;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + LENWIDTH'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            beat_cnt_reg  <= '0;
            len_q_reg     <= '0;
            pkt_done_reg  <= 1'b0;
            pkt_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            beat_cnt_reg  <= beat_cnt_next;
            len_q_reg     <= len_q_next;
            pkt_done_reg  <= accept & tag_last;
            pkt_count_reg <= pkt_count_reg + PKT_CNT_W'(accept & tag_last);
        end
    end

    assign in_beat.last = tag_last;
    assign in_beat.data = s_axis.tdata;

    axis_skid_buf #(
        .WIDTH(WIDTH + 1)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_beat),
        .in_valid (s_axis.tvalid),
        .in_ready (s_ready),
        .out_data (out_beat),
        .out_valid(m_axis.tvalid),
        .out_ready(m_axis.tready)
    );

    assign s_axis.tready = s_ready;
    assign m_axis.tdata  = out_beat.data;
    assign m_axis.tlast  = out_beat.last;
    assign pkt_done      = pkt_done_reg;
    assign pkt_count     = pkt_count_reg;

endmodule

// File: tb/tb_axis_packetizer.sv
// Directed bench for axis_packetizer: vector table plus hand-written stall,
// reset and counter-wrap sequences.
module tb_axis_packetizer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  cfg_len = 5'd4;
    logic        pkt_done;
    logic [15:0] pkt_count;

    int total = 0;
    int bad   = 0;

    axis_if #(.WIDTH(8)) s_axis ();
    axis_if #(.WIDTH(8)) m_axis ();

    axis_packetizer #(.WIDTH(8), .MAX_LEN(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_len  (cfg_len),
        .s_axis   (s_axis),
        .m_axis   (m_axis),
        .pkt_done (pkt_done),
        .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] cfg;
        logic [7:0] data;
        logic       last;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat with the sink always ready, then check it one edge later.
    task automatic send_beat(input logic [4:0] cfg, input logic [7:0] d, input logic exp_last);
        int g = 0;
        cfg_len       = cfg;
        s_axis.tdata  = d;
        s_axis.tvalid = 1'b1;
        while (!s_axis.tready && g < 20) begin
            tick();
            g++;
        end
        if (!s_axis.tready) begin
            check("s_ready_timeout", 32'(s_axis.tready), 32'd1);
        end else begin
            tick();
            check("out_valid", 32'(m_axis.tvalid), 32'd1);
            check("out_data",  32'(m_axis.tdata),  32'(d));
            check("out_last",  32'(m_axis.tlast),  32'(exp_last));
            check("pkt_done",  32'(pkt_done),      32'(exp_last));
            $display("beat cfg=%0d data=0x%02h last=%0b done=%0b count=%0d",
                     cfg, m_axis.tdata, m_axis.tlast, pkt_done, pkt_count);
        end
        s_axis.tvalid = 1'b0;
    endtask

    initial begin
        int exp_count;
        int sent, rcvd, held, cyc;
        logic       prev_stall;
        logic [7:0] prev_data;
        logic       prev_last;
        logic       push, pop;
        int n, guard;

        s_axis.tdata  = '0;
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        m_axis.tready = 1'b1;

        // Vector table: basic framing, length clamping, mid-packet cfg change.
        for (int k = 0; k < 8; k++)  vecs.push_back('{5'd4, 8'(k), (k % 4) == 3});
        for (int k = 0; k < 3; k++)  vecs.push_back('{5'd0, 8'(8'h20 + k), 1'b1});
        for (int k = 0; k < 32; k++) vecs.push_back('{5'd20, 8'(8'h40 + k), (k % 16) == 15});
        vecs.push_back('{5'd4, 8'h80, 1'b0});
        vecs.push_back('{5'd2, 8'h81, 1'b0});
        vecs.push_back('{5'd2, 8'h82, 1'b0});
        vecs.push_back('{5'd2, 8'h83, 1'b1});
        vecs.push_back('{5'd2, 8'h84, 1'b0});
        vecs.push_back('{5'd2, 8'h85, 1'b1});

        // Reset state
        tick();
        tick();
        check("rst_s_ready", 32'(s_axis.tready), 32'd0);
        check("rst_m_valid", 32'(m_axis.tvalid), 32'd0);
        check("rst_m_data",  32'(m_axis.tdata),  32'd0);
        check("rst_m_last",  32'(m_axis.tlast),  32'd0);
        check("rst_done",    32'(pkt_done),      32'd0);
        check("rst_count",   32'(pkt_count),     32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_s_ready", 32'(s_axis.tready), 32'd1);
        check("post_rst_m_valid", 32'(m_axis.tvalid), 32'd0);
        $display("reset ok s_ready=%0b m_valid=%0b count=%0d", s_axis.tready, m_axis.tvalid, pkt_count);

        exp_count = 0;
        foreach (vecs[i]) begin
            send_beat(vecs[i].cfg, vecs[i].data, vecs[i].last);
            if (vecs[i].last) exp_count++;
            if (i == 7) check("count_after_len4", 32'(pkt_count), 32'd2);
        end
        check("count_after_table", 32'(pkt_count), 32'(exp_count));
        tick();
        check("drained_valid", 32'(m_axis.tvalid), 32'd0);
        check("idle_done",     32'(pkt_done),      32'd0);

        // Backpressure: sink ready toggles, source always offers.
        cfg_len    = 5'd3;
        sent       = 0;
        rcvd       = 0;
        held       = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        while (rcvd < 12 && cyc < 200) begin
            if (prev_stall) begin
                check("stall_valid", 32'(m_axis.tvalid), 32'd1);
                check("stall_data",  32'(m_axis.tdata),  32'(prev_data));
                check("stall_last",  32'(m_axis.tlast),  32'(prev_last));
            end
            check("ready_vs_fill", 32'(s_axis.tready), 32'(held < 2));
            m_axis.tready = (cyc % 2) == 0;
            s_axis.tvalid = (sent < 12);
            s_axis.tdata  = 8'(8'h10 + sent);
            push = s_axis.tvalid && s_axis.tready;
            pop  = m_axis.tvalid && m_axis.tready;
            if (pop) begin
                check("bp_data", 32'(m_axis.tdata), 32'(8'h10 + rcvd));
                check("bp_last", 32'(m_axis.tlast), 32'((rcvd % 3) == 2));
                $display("bp beat data=0x%02h last=%0b held=%0d", m_axis.tdata, m_axis.tlast, held);
                rcvd++;
            end
            prev_stall = m_axis.tvalid && !m_axis.tready;
            prev_data  = m_axis.tdata;
            prev_last  = m_axis.tlast;
            if (push) sent++;
            held = held + int'(push) - int'(pop);
            tick();
            cyc++;
        end
        s_axis.tvalid = 1'b0;
        check("bp_received", 32'(rcvd), 32'd12);
        m_axis.tready = 1'b1;
        tick();
        tick();
        check("bp_empty", 32'(m_axis.tvalid), 32'd0);

        // Reset mid-packet with both skid entries held.
        m_axis.tready = 1'b0;
        cfg_len       = 5'd4;
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = 8'hC0;
        tick();
        s_axis.tdata  = 8'hC1;
        tick();
        s_axis.tvalid = 1'b0;
        check("full_s_ready", 32'(s_axis.tready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_m_valid", 32'(m_axis.tvalid), 32'd0);
        check("midrst_count",   32'(pkt_count),     32'd0);
        $display("mid-packet reset m_valid=%0b count=%0d", m_axis.tvalid, pkt_count);
        m_axis.tready = 1'b1;
        send_beat(5'd2, 8'hD0, 1'b0);
        send_beat(5'd2, 8'hD1, 1'b1);
        check("midrst_count_after", 32'(pkt_count), 32'd1);

        // Counter wrap: 65535 one-beat packets, then one more.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cfg_len       = 5'd1;
        s_axis.tdata  = 8'h55;
        s_axis.tvalid = 1'b1;
        n     = 0;
        guard = 0;
        while (n < 65535 && guard < 70000) begin
            if (s_axis.tready) n++;
            tick();
            guard++;
        end
        s_axis.tvalid = 1'b0;
        check("wrap_pre", 32'(pkt_count), 32'hFFFF);
        $display("pre-wrap count=0x%04h", pkt_count);
        send_beat(5'd1, 8'hEE, 1'b1);
        check("wrap_post", 32'(pkt_count), 32'h0000);
        $display("post-wrap count=0x%04h", pkt_count);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
